// File: rtl/cmd_frame_parser.sv
// Byte-stream framer: finds AA 55 frames, checks length/checksum, buffers the payload,
// then replays validated frames onto the command bus as start / indexed beats / done.
module cmd_frame_parser #(
  parameter int MAX_PAYLOAD    = 64,
  parameter int TIMEOUT_CYCLES = 600000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic [7:0]  cmd_data,
  output logic [15:0] cmd_data_index,
  output logic        cmd_start,
  output logic        cmd_data_valid,
  output logic        cmd_done,
  input  logic        cmd_ready,
  output logic        err_pulse,
  output logic [1:0]  err_code
);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] MAXP     = 16'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_SYNC1, S_SYNC2, S_CMD, S_LENH, S_LENL, S_PAY, S_CSUM, S_START, S_DATA, S_DONE
  } state_t;

  state_t        state_q;
  logic [7:0]    csum_q, cmd_q, lenh_q;
  logic [15:0]   len_q, wr_idx_q, rd_idx_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    buf_q [MAX_PAYLOAD];
  logic [7:0]    cmd_type_q, cmd_data_q;
  logic [15:0]   cmd_length_q, cmd_index_q;
  logic          cmd_start_q, cmd_valid_q, cmd_done_q, err_pulse_q;
  logic [1:0]    err_code_q;

  logic          accept, rx_active;
  logic [15:0]   len_full, wr_nxt, rd_nxt;
  logic [7:0]    csum_add;

  assign in_ready  = (state_q <= S_CSUM);
  assign accept    = in_valid && in_ready;
  assign rx_active = in_ready && (state_q != S_SYNC1);
  assign len_full  = {lenh_q, in_data};
  assign csum_add  = csum_q + in_data;
  assign wr_nxt    = wr_idx_q + 16'd1;
  assign rd_nxt    = rd_idx_q + 16'd1;

  // Payload storage carries no reset; it is always written before being read.
  always_ff @(posedge clk) begin
    if (accept && state_q == S_PAY) buf_q[wr_idx_q[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SYNC1;
      csum_q       <= '0;
      cmd_q        <= '0;
      lenh_q       <= '0;
      len_q        <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      tmo_q        <= '0;
      cmd_type_q   <= '0;
      cmd_length_q <= '0;
      cmd_data_q   <= '0;
      cmd_index_q  <= '0;
      cmd_start_q  <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_done_q   <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      cmd_start_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      err_pulse_q <= 1'b0;

      // Inter-byte watchdog; only idle receive cycles advance it.
      if (rx_active && !accept) begin
        if (tmo_q == TMO_LAST) begin
          tmo_q       <= '0;
          err_code_q  <= 2'd3;
          err_pulse_q <= 1'b1;
          state_q     <= S_SYNC1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end

      case (state_q)
        S_SYNC1: if (accept && in_data == 8'hAA) state_q <= S_SYNC2;
        S_SYNC2: if (accept) begin
          if (in_data == 8'h55)      state_q <= S_CMD;
          else if (in_data != 8'hAA) state_q <= S_SYNC1;
        end
        S_CMD: if (accept) begin
          cmd_q   <= in_data;
          csum_q  <= in_data;
          state_q <= S_LENH;
        end
        S_LENH: if (accept) begin
          lenh_q  <= in_data;
          csum_q  <= csum_add;
          state_q <= S_LENL;
        end
        S_LENL: if (accept) begin
          csum_q   <= csum_add;
          len_q    <= len_full;
          wr_idx_q <= '0;
          if (len_full > MAXP) begin
            err_code_q  <= 2'd2;
            err_pulse_q <= 1'b1;
            state_q     <= S_SYNC1;
          end else if (len_full == 16'd0) begin
            state_q <= S_CSUM;
          end else begin
            state_q <= S_PAY;
          end
        end
        S_PAY: if (accept) begin
          csum_q   <= csum_add;
          wr_idx_q <= wr_nxt;
          if (wr_nxt == len_q) state_q <= S_CSUM;
        end
        S_CSUM: if (accept) begin
          if (in_data == csum_q) begin
            cmd_type_q   <= cmd_q;
            cmd_length_q <= len_q;
            cmd_start_q  <= 1'b1;
            state_q      <= S_START;
          end else begin
            err_code_q  <= 2'd1;
            err_pulse_q <= 1'b1;
            state_q     <= S_SYNC1;
          end
        end
        S_START: begin
          rd_idx_q <= '0;
          if (len_q == 16'd0) begin
            cmd_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= buf_q[0];
            cmd_index_q <= '0;
            state_q     <= S_DATA;
          end
        end
        S_DATA: if (cmd_ready) begin
          if (rd_nxt < len_q) begin
            rd_idx_q    <= rd_nxt;
            cmd_data_q  <= buf_q[rd_nxt[AW-1:0]];
            cmd_index_q <= rd_nxt;
          end else begin
            cmd_valid_q <= 1'b0;
            cmd_done_q  <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_SYNC1;
        default: state_q <= S_SYNC1;
      endcase
    end
  end

  assign cmd_type       = cmd_type_q;
  assign cmd_length     = cmd_length_q;
  assign cmd_data       = cmd_data_q;
  assign cmd_data_index = cmd_index_q;
  assign cmd_start      = cmd_start_q;
  assign cmd_data_valid = cmd_valid_q;
  assign cmd_done       = cmd_done_q;
  assign err_pulse      = err_pulse_q;
  assign err_code       = err_code_q;
endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: hand-built frames, bus monitor, latency checks.
module tb_cmd_frame_parser;
  localparam int TMO = 40;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  cmd_type, cmd_data;
  logic [15:0] cmd_length, cmd_data_index;
  logic        cmd_start, cmd_data_valid, cmd_done, cmd_ready = 1'b1;
  logic        err_pulse;
  logic [1:0]  err_code;

  cmd_frame_parser #(.MAX_PAYLOAD(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
    .cmd_data_index(cmd_data_index), .cmd_start(cmd_start), .cmd_data_valid(cmd_data_valid),
    .cmd_done(cmd_done), .cmd_ready(cmd_ready), .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; value c labels the cycle following edge c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor
  int start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int start_cyc = 0, done_cyc = 0, err_cyc = 0, rdy_cyc = 0;
  logic [1:0]  err_seen = '0;
  logic        in_disp = 1'b0, wait_rdy = 1'b0, stalled = 1'b0;
  logic [7:0]  hold_d = '0, st_type = '0;
  logic [15:0] hold_i = '0, st_len = '0;
  logic [7:0]  bd[$];
  int          bi[$], bc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      in_disp = 1'b0; wait_rdy = 1'b0; stalled = 1'b0;
    end else begin
      int act;
      act = int'(cmd_start) + int'(cmd_data_valid) + int'(cmd_done);
      if (act > 0) chk("bus_exclusive", act, 1);
      if (stalled) begin
        chk("stall_hold_data", cmd_data, hold_d);
        chk("stall_hold_index", cmd_data_index, hold_i);
      end
      stalled = cmd_data_valid && !cmd_ready;
      hold_d  = cmd_data;
      hold_i  = cmd_data_index;
      if (cmd_start) begin
        start_cnt++; start_cyc = cyc; st_type = cmd_type; st_len = cmd_length; in_disp = 1'b1;
      end else if (in_disp) begin
        chk("type_stable", cmd_type, st_type);
        chk("length_stable", cmd_length, st_len);
      end
      if (in_disp) chk("in_ready_dispatch", in_ready, 0);
      if (cmd_data_valid && cmd_ready) begin
        bd.push_back(cmd_data); bi.push_back(int'(cmd_data_index)); bc.push_back(cyc);
      end
      if (cmd_done) begin
        done_cnt++; done_cyc = cyc; in_disp = 1'b0; wait_rdy = 1'b1;
      end else if (wait_rdy && in_ready) begin
        rdy_cyc = cyc; wait_rdy = 1'b0;
      end
      if (err_pulse) begin
        err_cnt++; err_cyc = cyc; err_seen = err_code;
      end
    end
  end

  int acc_edge = 0;
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    acc_edge = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f);
    foreach (f[i]) send(f[i]);
  endtask

  task automatic clear_beats();
    bd.delete(); bi.delete(); bc.delete();
  endtask

  task automatic expect_dispatch(input string tag, input logic [7:0] ty, input int len,
                                 input bq_t pay, input int s0, input int d0, input int e0,
                                 input int stall_at, input int stall_len);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_start_cnt"}, start_cnt, s0 + 1);
    chk({tag, "_done_cnt"}, done_cnt, d0 + 1);
    chk({tag, "_no_err"}, err_cnt, e0);
    chk({tag, "_type"}, st_type, ty);
    chk({tag, "_length"}, st_len, len);
    chk({tag, "_start_lat"}, start_cyc - acc_edge + 1, 1);
    chk({tag, "_beats"}, bd.size(), len);
    for (int k = 0; k < len && k < bd.size(); k++) begin
      chk({tag, "_beat_data"}, bd[k], pay[k]);
      chk({tag, "_beat_index"}, bi[k], k);
      chk({tag, "_beat_lat"}, bc[k] - acc_edge + 1, 2 + k + ((k >= stall_at) ? stall_len : 0));
    end
    chk({tag, "_done_lat"}, done_cyc - acc_edge + 1, 2 + len + stall_len);
    chk({tag, "_ready_lat"}, rdy_cyc - acc_edge + 1, 3 + len + stall_len);
  endtask

  bq_t fa, fbad, fz, fnoise, flen, ftmo, pa, pnone;
  int s0, d0, e0;

  initial begin
    fa     = '{8'hAA, 8'h55, 8'hF0, 8'h00, 8'h0D, 8'h00, 8'h01, 8'h00, 8'h3C, 8'h0A,
               8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9A};
    fbad   = fa; fbad[18] = 8'h9B;
    pa     = '{8'h00, 8'h01, 8'h00, 8'h3C, 8'h0A, 8'h55, 8'h01, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fz     = '{8'hAA, 8'h55, 8'h10, 8'h00, 8'h00, 8'h10};
    fnoise = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h10, 8'h00, 8'h00, 8'h10};
    flen   = '{8'hAA, 8'h55, 8'h20, 8'h00, 8'h41};
    ftmo   = '{8'hAA, 8'h55, 8'hF0, 8'h00};
    pnone  = {};

    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", cmd_start, 0);
    chk("rst_valid", cmd_data_valid, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_type", cmd_type, 0);
    chk("rst_length", cmd_length, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_index", cmd_data_index, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Sequence-config frame, consumer always ready
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; clear_beats();
    send_frame(fa);
    expect_dispatch("seq", 8'hF0, 13, pa, s0, d0, e0, 99, 0);

    // Bad checksum is dropped, following frame still dispatches
    s0 = start_cnt; e0 = err_cnt;
    send_frame(fbad);
    repeat (3) @(negedge clk);
    chk("cs_no_start", start_cnt, s0);
    chk("cs_err_cnt", err_cnt, e0 + 1);
    chk("cs_err_code", err_seen, 1);
    chk("cs_err_lat", err_cyc - acc_edge + 1, 1);
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; clear_beats();
    send_frame(fz);
    expect_dispatch("after_cs", 8'h10, 0, pnone, s0, d0, e0, 99, 0);

    // Noise and repeated AA ahead of a zero-length frame
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; clear_beats();
    send_frame(fnoise);
    expect_dispatch("noise", 8'h10, 0, pnone, s0, d0, e0, 99, 0);

    // Oversize length rejected right after LEN_L
    s0 = start_cnt; e0 = err_cnt;
    send_frame(flen);
    repeat (2) @(negedge clk);
    chk("len_err_cnt", err_cnt, e0 + 1);
    chk("len_err_code", err_seen, 2);
    chk("len_err_lat", err_cyc - acc_edge + 1, 1);
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; clear_beats();
    send(8'h00);
    send_frame(fz);
    expect_dispatch("after_len", 8'h10, 0, pnone, s0, d0, e0, 99, 0);

    // Stalled header times out
    s0 = start_cnt; e0 = err_cnt;
    send_frame(ftmo);
    begin
      int n = 0;
      while (err_cnt == e0 && n < TMO + 20) begin @(negedge clk); n++; end
    end
    chk("tmo_err_cnt", err_cnt, e0 + 1);
    chk("tmo_err_code", err_seen, 3);
    chk("tmo_idle_cycles", err_cyc - acc_edge, TMO);
    chk("tmo_no_start", start_cnt, s0);
    @(posedge clk); #1;
    chk("tmo_in_ready", in_ready, 1);
    chk("tmo_err_pulse_single", err_pulse, 0);

    // Consumer stalls 5 cycles on beat 4
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; clear_beats();
    fork
      send_frame(fa);
      begin
        int n = 0;
        while (n < 400) begin
          @(posedge clk); #1; n++;
          if (cmd_data_valid && cmd_data_index == 16'd4 && cmd_ready) begin
            cmd_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 cmd_ready = 1'b1;
            break;
          end
        end
      end
    join
    expect_dispatch("stall", 8'hF0, 13, pa, s0, d0, e0, 4, 5);

    // Reset in the middle of a dispatch aborts without cmd_done
    cmd_ready = 1'b0; d0 = done_cnt; clear_beats();
    send_frame(fa);
    repeat (4) @(negedge clk);
    chk("mid_valid_before_rst", cmd_data_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", cmd_data_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_type", cmd_type, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; cmd_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, d0);
    chk("mid_rst_no_beats", bd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Byte-stream framing stage directly upstream of the command-bus consumers, including the sequence-generator handler that takes command 0xF0. It receives raw bytes from the UART/USB receive path, finds `AA 55` frames, checks length and checksum, and buffers the payload. It then replays each validated frame onto the shared command bus as start pulse, indexed data beats and done pulse. Corrupt, oversize or stalled frames are dropped and reported, and never reach the bus.

## Interface
- MAX_PAYLOAD, 64: payload buffer depth in bytes. Frames with a larger length are rejected.
- TIMEOUT_CYCLES, 600000: maximum idle clocks between bytes inside a frame (10 ms at 60 MHz).
- clk  input  1  system clock. One clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  received byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  parser accepts a byte this cycle. A byte transfers when in_valid and in_ready are both high.
- cmd_type  output  8  command code of the frame being dispatched.
- cmd_length  output  16  payload length of the frame being dispatched.
- cmd_data  output  8  payload byte.
- cmd_data_index  output  16  payload byte index, 0-based.
- cmd_start  output  1  one-cycle pulse that opens a dispatch.
- cmd_data_valid  output  1  cmd_data and cmd_data_index are valid.
- cmd_done  output  1  one-cycle pulse that closes a dispatch.
- cmd_ready  input  1  consumer can take a data beat.
- err_pulse  output  1  one-cycle pulse when a frame is dropped.
- err_code  output  2  reason for the drop, held until the next error: 1 = checksum, 2 = length, 3 = timeout.

## Operation
- Frame format: `AA 55 CMD LEN_H LEN_L P[0..LEN-1] CS`.
- Checksum rule: CS = low 8 bits of (CMD + LEN_H + LEN_L + sum of all payload bytes).
- FSM states: S_SYNC1, S_SYNC2, S_CMD, S_LENH, S_LENL, S_PAY, S_CSUM, S_START, S_DATA, S_DONE.
- S_SYNC1: wait for AA. Any other byte is discarded silently.
- S_SYNC2: 55 -> S_CMD. AA -> stay in S_SYNC2. Any other byte -> S_SYNC1. No error is reported.
- S_CMD, S_LENH, S_LENL: latch CMD, LEN_H and LEN_L into the running checksum.
  - After LEN_L, length > MAX_PAYLOAD: err_code=2 and err_pulse, then go to S_SYNC1.
  - After LEN_L, length = 0: go to S_CSUM.
  - Otherwise go to S_PAY.
- S_PAY: write each byte to buffer[wr_idx] and add it to the checksum. After LEN bytes, go to S_CSUM.
- S_CSUM: compare the received byte with the checksum. Match -> S_START. Mismatch -> err_code=1, err_pulse, S_SYNC1.
- S_START: cmd_start=1 for one cycle, then S_DATA. cmd_type and cmd_length are loaded before or at this cycle. They stay stable until the cycle after cmd_done.
- S_DATA: cmd_data_valid = 1 while rd_idx < LEN, presenting buffer[rd_idx] with cmd_data_index = rd_idx.
  - A beat completes on a cycle where cmd_data_valid and cmd_ready are both high; rd_idx then increments.
  - While cmd_ready is low, cmd_data and cmd_data_index hold.
  - After the last beat (or immediately when LEN = 0), go to S_DONE.
- S_DONE: cmd_done=1 for one cycle, then S_SYNC1.
- in_ready is 1 only in states S_SYNC1 through S_CSUM. It is 0 during S_START, S_DATA and S_DONE.
- Timeout: a counter is cleared on every accepted byte and runs in S_SYNC2 through S_CSUM. When it reaches TIMEOUT_CYCLES: err_code=3, err_pulse, S_SYNC1. The partial frame is discarded.
- cmd_type 8'hF0 gets no special treatment. All codes are dispatched identically.
- Width rules:
  - Checksum is an 8-bit wrap-around adder.
  - wr_idx and rd_idx are 16 bits.
  - The buffer is MAX_PAYLOAD x 8 and is addressed by the low clog2(MAX_PAYLOAD) bits.

## Timing
- Reset values:
  - All cmd_* outputs = 0.
  - err_pulse = 0, err_code = 0.
  - in_ready = 1.
  - FSM in S_SYNC1; checksum, indices and timeout counter = 0.
- Reset mid-dispatch aborts immediately. No cmd_done is issued.
- Latency, with the CS byte accepted at edge N:
  - cmd_start is high in cycle N+1.
  - The first cmd_data_valid is in cycle N+2.
  - With cmd_ready held high, beat k is in cycle N+2+k.
  - cmd_done is in cycle N+2+LEN.
  - in_ready returns high in cycle N+3+LEN.
- cmd_start, cmd_data_valid and cmd_done are never high in the same cycle.
- err_pulse is high in the cycle after the offending byte is accepted, or after the timeout count is reached.
- A back-to-back frame can begin as soon as in_ready returns. There is no additional gap requirement.

## Test plan
- Sequence config frame `AA 55 F0 00 0D 00 01 00 3C 0A 55 01 00 00 00 00 00 00 9A`, cmd_ready=1 -> cmd_start with cmd_type=F0 and cmd_length=13; 13 beats with index 0..12 carrying data 00,01,00,3C,0A,55,01,00...; cmd_done at N+15; err_pulse never asserted.
- Same frame with CS=9B -> no cmd_start; err_pulse with err_code=1; a following valid frame dispatches normally.
- Prefix noise `12 AA AA 55` then `10 00 00 10` -> dispatch with cmd_type=10 and cmd_length=0; cmd_start at N+1, cmd_done at N+2, zero data beats.
- Header `AA 55 20 00 41` (length 65) -> err_code=2 right after LEN_L; the next bytes are treated as sync search.
- `AA 55 F0 00` followed by TIMEOUT_CYCLES idle clocks -> err_code=3; FSM back in S_SYNC1; in_ready=1.
- Valid 13-byte frame with cmd_ready low for 5 cycles at beat 4 -> beat 4 is held stable (same data and index) across the stall; all 13 beats still delivered in order; cmd_done 5 cycles later than in the unstalled case; in_ready stays 0 throughout the dispatch.
